// File: rtl/sd_clock_gen_v2.sv
// sd_clock_gen_v2: SD/eMMC card-clock generator (f_axi/(2(N+1))) with stabilisation,
// glitch-free start/stop, live divisor change, quadrature clock and edge strobes.
module sd_clock_gen_v2 #(
  parameter int DIV_W         = 10,
  parameter int STABLE_CYCLES = 16
) (
  input  logic             AXI_CLOCK,
  input  logic             AXI_RST,
  input  logic             int_clk_en,
  input  logic             sd_clk_en,
  input  logic [DIV_W-1:0] divisor,
  input  logic             div_update,
  output logic             sd_clk,
  output logic             sd_clk90,
  output logic             sd_clk_rise,
  output logic             sd_clk_fall,
  output logic             internal_clk_stable,
  output logic             clk_running,
  output logic [DIV_W-1:0] div_active
);
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  typedef enum logic [2:0] {OFF, STARTUP, STOPPED, RUNNING, STOPPING} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d, shadow_q, shadow_d;
  logic pend_q, pend_d, clk_q, clk_d, rise_q, fall_q, q90_q, q90_d, neg_q;
  logic tog, run_nxt, apply;
  always_ff @(posedge AXI_CLOCK or posedge AXI_RST)
    if (AXI_RST) state_q <= OFF;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      OFF:      state_d = STARTUP;
      STARTUP:  if (stab_q == SW'(STABLE_CYCLES - 1)) state_d = STOPPED;
      STOPPED:  if (sd_clk_en) state_d = RUNNING;
      RUNNING:  if (!sd_clk_en) state_d = (clk_q && !tog) ? STOPPING : STOPPED;
      STOPPING: if (tog) state_d = STOPPED;
      default:  state_d = OFF;
    endcase
    if (!int_clk_en) state_d = OFF;
  end
  always_comb begin
    clk_running         = state_q == RUNNING || state_q == STOPPING;
    internal_clk_stable = clk_running || state_q == STOPPED;
  end
  assign tog     = clk_running && cnt_q == div_q;
  assign run_nxt = state_d == RUNNING || state_d == STOPPING;
  assign apply   = tog && clk_q && pend_q;
  // A toggle into a stopped state is only allowed when it drives sd_clk low.
  always_comb begin
    stab_d   = state_q == STARTUP ? stab_q + 1'b1 : '0;
    cnt_d    = (clk_running && run_nxt && !tog) ? cnt_q + 1'b1 : '0;
    clk_d    = clk_running && state_d != OFF && (tog ? !clk_q && run_nxt : clk_q);
    q90_d    = (!clk_running || state_d == OFF) ? 1'b0 : (cnt_q == div_q >> 1) ? clk_q : q90_q;
    shadow_d = clk_running && div_update ? divisor : shadow_q;
    div_d    = !clk_running && div_update ? divisor :
               ((!clk_running || apply) && pend_q) ? shadow_q : div_q;
    pend_d   = clk_running && div_update ? 1'b1 : (!clk_running || apply) ? 1'b0 : pend_q;
  end
  always_ff @(posedge AXI_CLOCK or posedge AXI_RST)
    if (AXI_RST) begin
      stab_q   <= '0;
      cnt_q    <= '0;
      div_q    <= '0;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      clk_q    <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      q90_q    <= 1'b0;
    end else begin
      stab_q   <= stab_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      clk_q    <= clk_d;
      rise_q   <= clk_d & ~clk_q;
      fall_q   <= ~clk_d & clk_q;
      q90_q    <= q90_d;
    end
  // Half-cycle lagged copy serves as the quadrature clock when N=0.
  always_ff @(negedge AXI_CLOCK or posedge AXI_RST)
    if (AXI_RST) neg_q <= 1'b0;
    else neg_q <= clk_q;
  assign sd_clk      = clk_q;
  assign sd_clk90    = div_q == '0 ? neg_q : q90_q;
  assign sd_clk_rise = rise_q;
  assign sd_clk_fall = fall_q;
  assign div_active  = div_q;
endmodule
